// File: rtl/portal_request_deframer.sv
// Reassembles 32-bit portal request beats (header word + payload words) into a
// single wide message presented on a guarded enqueue to the user logic.
module portal_request_deframer #(
  parameter int MAX_WORDS = 4
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    in_enq__ENA,
  input  logic [31:0]             in_enq_v,
  input  logic                    in_enq_last,
  output logic                    in_enq__RDY,
  output logic                    msg_enq__ENA,
  output logic [15:0]             msg_enq_id,
  output logic [7:0]              msg_enq_len,
  output logic [32*MAX_WORDS-1:0] msg_enq_data,
  input  logic                    msg_enq__RDY,
  output logic [7:0]              err_count
);

  // state | meaning
  // HDR   | waiting for a header beat
  // PAY   | collecting payload words into data[idx]
  // DROP  | discarding payload of an oversize header
  // OUT   | message presented, waiting for consumer
  localparam logic [1:0] HDR  = 2'd0;
  localparam logic [1:0] PAY  = 2'd1;
  localparam logic [1:0] DROP = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

  logic [1:0]              state;
  logic [15:0]             id_q;
  logic [7:0]              len_q;
  logic [32*MAX_WORDS-1:0] data_q;
  logic [7:0]              idx;
  logic [7:0]              remaining;
  logic [7:0]              err_q;
  logic                    beat_ok;
  logic                    hand_ok;
  logic [7:0]              hdr_len;

  // The last flag and header bits [15:8] carry no framing information.
  logic unused_ok;
  assign unused_ok = ^{in_enq_last, in_enq_v[15:8]};

  assign beat_ok = in_enq__ENA && (state != OUT);
  assign hand_ok = msg_enq__RDY && (state == OUT);
  assign hdr_len = in_enq_v[7:0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= HDR;
      id_q      <= '0;
      len_q     <= '0;
      data_q    <= '0;
      idx       <= '0;
      remaining <= '0;
      err_q     <= '0;
    end else begin
      case (state)
        HDR: begin
          if (beat_ok) begin
            id_q   <= in_enq_v[31:16];
            len_q  <= hdr_len;
            data_q <= '0;
            idx    <= '0;
            if (hdr_len == 8'd0) begin
              state <= OUT;
            end else if (hdr_len > MAX_LEN) begin
              state     <= DROP;
              remaining <= hdr_len;
              if (err_q != 8'hFF) err_q <= err_q + 8'd1;
            end else begin
              state <= PAY;
            end
          end
        end
        PAY: begin
          if (beat_ok) begin
            for (int i = 0; i < MAX_WORDS; i++) begin
              if (idx == 8'(i)) data_q[32*i +: 32] <= in_enq_v;
            end
            idx <= idx + 8'd1;
            if (idx == len_q - 8'd1) state <= OUT;
          end
        end
        DROP: begin
          if (beat_ok) begin
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) state <= HDR;
          end
        end
        default: begin
          if (hand_ok) state <= HDR;
        end
      endcase
    end
  end

  assign in_enq__RDY  = (state != OUT);
  assign msg_enq__ENA = (state == OUT);
  assign msg_enq_id   = id_q;
  assign msg_enq_len  = len_q;
  assign msg_enq_data = data_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_portal_request_deframer.sv
// Directed framing scenarios plus randomized message traffic checked against a
// message-level reference queue.
module tb_portal_request_deframer;
  localparam int MW = 4;
  localparam int DW = 32*MW;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          in_ena = 1'b0;
  logic [31:0]   in_v = '0;
  logic          in_last = 1'b0;
  logic          in_rdy;
  logic          msg_ena;
  logic [15:0]   msg_id;
  logic [7:0]    msg_len;
  logic [DW-1:0] msg_data;
  logic          msg_rdy = 1'b0;
  logic [7:0]    err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0]   id;
    logic [7:0]    len;
    logic [DW-1:0] data;
  } msg_t;

  msg_t exp_q[$];
  bit   auto_mode = 0;
  int   model_err = 0;

  always #5 CLK = ~CLK;

  portal_request_deframer #(.MAX_WORDS(MW)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_enq__ENA  (in_ena),
    .in_enq_v     (in_v),
    .in_enq_last  (in_last),
    .in_enq__RDY  (in_rdy),
    .msg_enq__ENA (msg_ena),
    .msg_enq_id   (msg_id),
    .msg_enq_len  (msg_len),
    .msg_enq_data (msg_data),
    .msg_enq__RDY (msg_rdy),
    .err_count    (err_cnt)
  );

  task automatic chk_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_beat(input logic [31:0] w);
    int n = 0;
    in_v   = w;
    in_ena = 1'b1;
    while (!in_rdy && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk_eq("beat_accept", in_rdy, 1'b1);
    @(negedge CLK);
    in_ena = 1'b0;
  endtask

  task automatic send_msg(input logic [15:0] id, input logic [7:0] len);
    msg_t        m;
    logic [31:0] words[$];
    m.id   = id;
    m.len  = len;
    m.data = '0;
    for (int i = 0; i < int'(len); i++) begin
      words.push_back($urandom);
      if (i < MW) m.data[32*i +: 32] = words[i];
    end
    if (int'(len) > MW) begin
      if (model_err < 255) model_err++;
    end else begin
      exp_q.push_back(m);
    end
    repeat ($urandom_range(0, 2)) @(negedge CLK);
    in_last = $urandom;
    send_beat({id, 8'($urandom), len});
    foreach (words[i]) begin
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      in_last = $urandom;
      send_beat(words[i]);
    end
  endtask

  // Random-phase monitor: drives consumer backpressure and scores messages.
  logic [15:0]   snap_id;
  logic [7:0]    snap_len;
  logic [DW-1:0] snap_data;
  bit            stall_prev = 0;
  always @(negedge CLK) begin
    if (auto_mode) begin
      msg_rdy = ($urandom_range(0, 9) < 7);
      chk_eq("rdy_vs_ena", in_rdy, !msg_ena);
      if (stall_prev) begin
        chk_eq("hold_ena", msg_ena, 1'b1);
        chk_eq("hold_id", msg_id, snap_id);
        chk_eq("hold_len", msg_len, snap_len);
        chk_eq("hold_data", msg_data, snap_data);
      end
      if (msg_ena && msg_rdy) begin
        chk_eq("msg_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          msg_t m;
          m = exp_q.pop_front();
          chk_eq("rnd_id", msg_id, m.id);
          chk_eq("rnd_len", msg_len, m.len);
          chk_eq("rnd_data", msg_data, m.data);
        end
      end
      stall_prev = msg_ena && !msg_rdy;
      snap_id    = msg_id;
      snap_len   = msg_len;
      snap_data  = msg_data;
    end else begin
      stall_prev = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge CLK);
    chk_eq("rst_in_rdy", in_rdy, 1'b1);
    chk_eq("rst_msg_ena", msg_ena, 1'b0);
    chk_eq("rst_id", msg_id, 16'h0);
    chk_eq("rst_len", msg_len, 8'h0);
    chk_eq("rst_data", msg_data, '0);
    chk_eq("rst_err", err_cnt, 8'h0);
    nRST = 1'b1;
    @(negedge CLK);

    // Two-word message
    msg_rdy = 1'b1;
    send_beat(32'h0005_0002);
    send_beat(32'hAAAA_0001);
    send_beat(32'hBBBB_0002);
    chk_eq("m1_ena", msg_ena, 1'b1);
    chk_eq("m1_id", msg_id, 16'h0005);
    chk_eq("m1_len", msg_len, 8'd2);
    chk_eq("m1_data", msg_data, {32'h0, 32'h0, 32'hBBBB_0002, 32'hAAAA_0001});
    chk_eq("m1_in_rdy_out", in_rdy, 1'b0);
    @(negedge CLK);
    chk_eq("m1_ena_done", msg_ena, 1'b0);
    chk_eq("m1_in_rdy_back", in_rdy, 1'b1);

    // Zero-length message
    send_beat(32'h0007_0000);
    chk_eq("m0_ena", msg_ena, 1'b1);
    chk_eq("m0_id", msg_id, 16'h0007);
    chk_eq("m0_len", msg_len, 8'd0);
    chk_eq("m0_data", msg_data, '0);
    @(negedge CLK);
    chk_eq("m0_done", msg_ena, 1'b0);

    // Oversize header is dropped, following message is intact
    send_beat(32'h0003_0006);
    for (int i = 0; i < 6; i++) send_beat(32'hDEAD_0000 + i);
    chk_eq("drop_no_msg", msg_ena, 1'b0);
    chk_eq("drop_err", err_cnt, 8'd1);
    send_beat(32'h0001_0001);
    send_beat(32'h1234_5678);
    chk_eq("after_drop_ena", msg_ena, 1'b1);
    chk_eq("after_drop_id", msg_id, 16'h0001);
    chk_eq("after_drop_len", msg_len, 8'd1);
    chk_eq("after_drop_data", msg_data, {96'h0, 32'h1234_5678});
    @(negedge CLK);

    // Backpressure with a pending input beat
    msg_rdy = 1'b0;
    send_beat(32'h0009_0001);
    send_beat(32'hCAFE_F00D);
    in_v   = 32'h00AA_0000;
    in_ena = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk_eq("bp_ena", msg_ena, 1'b1);
      chk_eq("bp_id", msg_id, 16'h0009);
      chk_eq("bp_data", msg_data, {96'h0, 32'hCAFE_F00D});
      chk_eq("bp_in_rdy", in_rdy, 1'b0);
      @(negedge CLK);
    end
    msg_rdy = 1'b1;
    @(negedge CLK);
    chk_eq("bp_release_ena", msg_ena, 1'b0);
    chk_eq("bp_release_rdy", in_rdy, 1'b1);
    @(negedge CLK);
    in_ena = 1'b0;
    chk_eq("bp_next_hdr_ena", msg_ena, 1'b1);
    chk_eq("bp_next_hdr_id", msg_id, 16'h00AA);
    chk_eq("bp_next_hdr_len", msg_len, 8'd0);
    @(negedge CLK);

    // Asynchronous reset in the middle of a message
    send_beat(32'h0004_0003);
    send_beat(32'h5555_0001);
    #2 nRST = 1'b0;
    #1;
    chk_eq("arst_in_rdy", in_rdy, 1'b1);
    chk_eq("arst_ena", msg_ena, 1'b0);
    chk_eq("arst_id", msg_id, 16'h0);
    chk_eq("arst_err", err_cnt, 8'h0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk_eq("arst_no_msg", msg_ena, 1'b0);
    send_beat(32'h0002_0000);
    chk_eq("arst_next_ena", msg_ena, 1'b1);
    chk_eq("arst_next_id", msg_id, 16'h0002);
    chk_eq("arst_next_len", msg_len, 8'd0);
    @(negedge CLK);

    // Error counter saturation
    for (int k = 1; k <= 256; k++) begin
      send_beat({16'(k), 16'h0005});
      for (int j = 0; j < 5; j++) send_beat($urandom);
      if (k == 1)   chk_eq("sat_err_1", err_cnt, 8'd1);
      if (k == 255) chk_eq("sat_err_255", err_cnt, 8'd255);
      if (k == 256) chk_eq("sat_err_256", err_cnt, 8'd255);
    end
    chk_eq("sat_no_msg", msg_ena, 1'b0);

    // Randomized traffic
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    model_err = 0;
    exp_q.delete();
    @(posedge CLK);
    #1 auto_mode = 1;
    @(negedge CLK);
    for (int n = 0; n < 150; n++) begin
      send_msg(16'($urandom), 8'($urandom_range(0, 6)));
    end
    in_ena = 1'b0;
    for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(negedge CLK);
    chk_eq("rnd_drained", exp_q.size(), 0);
    chk_eq("rnd_err", err_cnt, 8'(model_err));
    @(posedge CLK);
    #1 auto_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/portal_request_deframer.md
# portal_request_deframer

Consumes the 32-bit request beat stream from the portal write datapath, i.e. the user-side write enqueue with data and last flag. Reassembles the beats into complete portal method invocations, each a header word followed by payload words. Presents each invocation as a single wide message on a guarded enqueue to the user logic. Sits directly downstream of the Zynq top's AXI write-beat path, in place of the raw UserTop write consumer.

## Interface
Parameters:
- MAX_WORDS, 4: maximum payload words per message (1..16); sets data bus width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- nRST  in  1  reset, asynchronous, active-low.
- in$enq__ENA  in  1  beat valid; transfer occurs when in$enq__ENA && in$enq__RDY.
- in$enq$v  in  32  beat data.
- in$enq$last  in  1  producer framing hint; ignored for framing (header length is authoritative).
- in$enq__RDY  out  1  deframer can accept a beat.
- msg$enq__ENA  out  1  complete message valid.
- msg$enq$id  out  16  method id from header [31:16].
- msg$enq$len  out  8  payload word count from header [7:0].
- msg$enq$data  out  32*MAX_WORDS  payload; word i at bits [32i+31:32i].
- msg$enq__RDY  in  1  consumer accepts; message handshake = msg$enq__ENA && msg$enq__RDY.
- err$count  out  8  count of oversize headers dropped, saturating at 255.

## Operation
States: HDR, PAY, DROP, OUT.

- HDR: in$enq__RDY=1. On a beat:
  - Latch id=v[31:16], len=v[7:0].
  - Clear all data words to 0.
  - Clear word index idx=0.
  - Next state: len==0 -> OUT; len>MAX_WORDS -> DROP (remaining=len) and err$count+1; else -> PAY.
  - Header bits [15:8] are ignored.
- PAY: in$enq__RDY=1. Each beat writes data word idx and increments idx. The beat with idx==len-1 moves to OUT.
- DROP: in$enq__RDY=1. Each beat is discarded and decrements remaining. The beat with remaining==1 moves to HDR. No message is emitted.
- OUT: in$enq__RDY=0, msg$enq__ENA=1; id, len and data are held stable. On the message handshake, move to HDR.
- err$count increments only on entry to DROP and saturates at 8'hFF.
- idx and remaining are 8-bit. idx never exceeds MAX_WORDS-1 in PAY.

## Timing
- Reset state (asynchronous, nRST low): state=HDR, in$enq__RDY=1, msg$enq__ENA=0, id=0, len=0, data=0, err$count=0, idx=0, remaining=0.
- Output derivation: in$enq__RDY and msg$enq__ENA are decoded from registered state only. There is no combinational path from any input to any output.
- Message latency: msg$enq__ENA rises the cycle after the final payload beat is accepted (the header beat when len==0).
- Throughput: an N-word message occupies N+1 input beats plus at least 1 OUT cycle. Minimum N+2 cycles per message at full rate.
- No beat is accepted in the cycle the message handshake occurs. in$enq__RDY returns high the following cycle.
- msg$enq__ENA stays high until msg$enq__RDY is seen. Outputs must not change while ENA is high and RDY is low.
- Reset asserted mid-message discards the partial message with no output. Deasserting reset returns to HDR; the next beat is treated as a header.
- in$enq__ENA while in$enq__RDY=0 has no effect on state.

## Test plan
- Header 32'h0005_0002, then beats 32'hAAAA0001 and 32'hBBBB0002 on consecutive cycles, msg$enq__RDY=1 -> one cycle after the 2nd payload beat: msg$enq__ENA=1, id=16'h0005, len=2, data word0=AAAA0001, word1=BBBB0002, words2..3=0. in$enq__RDY=0 that cycle and 1 the next.
- Header 32'h0007_0000 -> msg$enq__ENA=1 the next cycle, id=7, len=0, data all 0, no payload consumed.
- MAX_WORDS=4, header 32'h0003_0006 followed by 6 beats, then header 32'h0001_0001 and beat 32'h12345678 -> no message for the first header; err$count=1; a second message id=1, len=1, word0=12345678.
- Backpressure: complete a 1-word message with msg$enq__RDY=0 for 5 cycles while in$enq__ENA=1 -> msg$enq__ENA and outputs are stable for 5 cycles, in$enq__RDY=0, and no input beats are consumed. With RDY=1 the message transfers once and the next beat is taken as a header.
- Assert nRST low asynchronously between cycles after the header plus 1 of 3 payload words, then release -> outputs are at reset values immediately and no message is emitted. The beat 32'h0002_0000 after release yields a message with id=2, len=0.
- Send 256 oversize headers (len=5, MAX_WORDS=4) with their payloads -> err$count=255 after the 255th and holds at 255 after the 256th.
